// File: rtl/shift_reg_loader_ctrl.sv
// Load controller for an external serial-in shift register: clears it, shifts a word in
// MSB- or LSB-first, then checks the parallel readback against the expected pattern.
module shift_reg_loader_ctrl #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned CLEAR_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             abort,
  output logic             sr_clear,
  output logic             sr_shift_en,
  output logic             sr_serial,
  input  logic [WIDTH-1:0] sr_q,
  output logic             done,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_CHECK, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] expect_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] ordered;

  // The word is stored in shift order, so the first bit out is always the top bit
  // and the stored word doubles as the expected readback.
  always_comb begin
    ordered = in_msb_first ? in_data : {<<{in_data}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      expect_q    <= '0;
      work_q      <= '0;
      in_ready    <= 1'b1;
      sr_clear    <= 1'b0;
      sr_shift_en <= 1'b0;
      sr_serial   <= 1'b0;
      done        <= 1'b0;
      out_data    <= '0;
      err         <= 1'b0;
      err_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          sr_clear <= 1'b0;
          if (in_valid && !abort) begin
            expect_q <= ordered;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (CLEAR_FIRST != 0) begin
              state    <= S_CLEAR;
              sr_clear <= 1'b1;
              work_q   <= ordered;
            end else begin
              state       <= S_SHIFT;
              sr_shift_en <= 1'b1;
              sr_serial   <= ordered[WIDTH-1];
              work_q      <= ordered << 1;
            end
          end
        end
        S_CLEAR: begin
          if (abort) begin
            state    <= S_IDLE;
            sr_clear <= 1'b1;
            in_ready <= 1'b1;
          end else begin
            state       <= S_SHIFT;
            sr_clear    <= 1'b0;
            sr_shift_en <= 1'b1;
            sr_serial   <= work_q[WIDTH-1];
            work_q      <= work_q << 1;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state       <= S_IDLE;
            sr_clear    <= 1'b1;
            sr_shift_en <= 1'b0;
            sr_serial   <= 1'b0;
            in_ready    <= 1'b1;
          end else if (cnt == LAST) begin
            state       <= S_CHECK;
            sr_shift_en <= 1'b0;
            sr_serial   <= 1'b0;
          end else begin
            cnt       <= cnt + 1'b1;
            sr_serial <= work_q[WIDTH-1];
            work_q    <= work_q << 1;
          end
        end
        S_CHECK: begin
          if (abort) begin
            state    <= S_IDLE;
            sr_clear <= 1'b1;
            in_ready <= 1'b1;
          end else begin
            state    <= S_DONE;
            out_data <= sr_q;
            err      <= (sr_q != expect_q);
            done     <= 1'b1;
          end
        end
        S_DONE: begin
          if (err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
          end
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_loader_ctrl.sv
// Bench for shift_reg_loader_ctrl: a behavioural shift register with optional stuck-at-0
// readback, directed and random loads checked against a cycle-level expectation model.
module tb_shift_reg_loader_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       in_msb_first = 1'b0;
  logic       abort = 1'b0;
  logic       sr_clear;
  logic       sr_shift_en;
  logic       sr_serial;
  logic [3:0] sr_q;
  logic       done;
  logic [3:0] out_data;
  logic       err;
  logic [7:0] err_cnt;

  logic [3:0] q_reg;
  logic       stuck = 1'b0;

  int unsigned npass  = 0;
  int unsigned ntotal = 0;

  logic [3:0]  prev_out = '0;
  logic        prev_err = 1'b0;
  int unsigned m_errcnt = 0;

  shift_reg_loader_ctrl #(.WIDTH(4), .CLEAR_FIRST(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_msb_first(in_msb_first), .abort(abort),
    .sr_clear(sr_clear), .sr_shift_en(sr_shift_en), .sr_serial(sr_serial),
    .sr_q(sr_q), .done(done), .out_data(out_data), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sr_clear) q_reg <= '0;
    else if (sr_shift_en) q_reg <= {q_reg[2:0], sr_serial};
  end
  assign sr_q = stuck ? 4'b0000 : q_reg;

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a falling edge with the controller idle; returns at the falling edge
  // where it is idle again. abort_at: 0 none, 1..6 abort sampled at that edge, 7 in DONE.
  task automatic do_load(input logic [3:0] d, input logic m, input int abort_at);
    logic       bits[$];
    logic [3:0] work;
    logic [3:0] exp_out;
    logic [3:0] expect_word;
    logic       exp_err;
    bits = {};
    work = d;
    for (int i = 0; i < 4; i++) begin
      bits.push_back(m ? work[3] : work[0]);
      work = m ? (work << 1) : (work >> 1);
    end
    exp_out = '0;
    foreach (bits[i]) exp_out = {exp_out[2:0], bits[i]};
    if (stuck) exp_out = '0;
    expect_word = m ? d : {d[0], d[1], d[2], d[3]};
    exp_err = (exp_out != expect_word);

    chk("ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = d; in_msb_first = m;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = 1'b0; in_data = 4'($urandom); in_msb_first = 1'($urandom);
      end
      if (abort_at > 0 && abort_at < 7 && c == abort_at + 1) begin
        chk("abort_clear",  32'(sr_clear), 1);
        chk("abort_shift",  32'(sr_shift_en), 0);
        chk("abort_serial", 32'(sr_serial), 0);
        chk("abort_ready",  32'(in_ready), 1);
        chk("abort_done",   32'(done), 0);
        chk("abort_out",    32'(out_data), 32'(prev_out));
        chk("abort_err",    32'(err), 32'(prev_err));
        chk("abort_errcnt", 32'(err_cnt), m_errcnt);
      end else if (abort_at > 0 && abort_at < 7 && c == abort_at + 2) begin
        chk("abort_clear_end", 32'(sr_clear), 0);
        chk("abort_no_done",   32'(done), 0);
        chk("abort_ready2",    32'(in_ready), 1);
        return;
      end else begin
        case (c)
          1: begin
            chk("clr_pulse",  32'(sr_clear), 1);
            chk("clr_shift",  32'(sr_shift_en), 0);
            chk("clr_serial", 32'(sr_serial), 0);
            chk("clr_ready",  32'(in_ready), 0);
          end
          2, 3, 4, 5: begin
            chk("sh_en",     32'(sr_shift_en), 1);
            chk("sh_clear",  32'(sr_clear), 0);
            chk("sh_serial", 32'(sr_serial), 32'(bits[c-2]));
            chk("sh_ready",  32'(in_ready), 0);
            chk("sh_done",   32'(done), 0);
          end
          6: begin
            chk("ck_shift",  32'(sr_shift_en), 0);
            chk("ck_serial", 32'(sr_serial), 0);
            chk("ck_clear",  32'(sr_clear), 0);
            chk("ck_done",   32'(done), 0);
          end
          7: begin
            chk("dn_done",   32'(done), 1);
            chk("dn_out",    32'(out_data), 32'(exp_out));
            chk("dn_err",    32'(err), 32'(exp_err));
            chk("dn_errcnt", 32'(err_cnt), m_errcnt);
            prev_out = exp_out;
            prev_err = exp_err;
            if (exp_err && m_errcnt < 255) m_errcnt++;
          end
          default: begin
            chk("end_done",   32'(done), 0);
            chk("end_ready",  32'(in_ready), 1);
            chk("end_out",    32'(out_data), 32'(prev_out));
            chk("end_err",    32'(err), 32'(prev_err));
            chk("end_errcnt", 32'(err_cnt), m_errcnt);
          end
        endcase
      end
      abort = (c == abort_at);
    end
    abort = 1'b0;
  endtask

  initial begin
    logic [3:0] pres [0:27];
    logic       exp_ready;
    logic       exp_done;

    #1 rst = 1'b0;
    #1;
    chk("rst_async_ready", 32'(in_ready), 1);
    @(negedge clk); @(negedge clk);
    chk("rst_ready",   32'(in_ready), 1);
    chk("rst_clear",   32'(sr_clear), 0);
    chk("rst_shift",   32'(sr_shift_en), 0);
    chk("rst_serial",  32'(sr_serial), 0);
    chk("rst_done",    32'(done), 0);
    chk("rst_out",     32'(out_data), 0);
    chk("rst_err",     32'(err), 0);
    chk("rst_errcnt",  32'(err_cnt), 0);
    rst = 1'b1;
    @(negedge clk);

    do_load(4'b1011, 1'b1, 0);
    do_load(4'b1011, 1'b0, 0);
    for (int i = 0; i < 10; i++) do_load(4'($urandom), 1'($urandom), 0);

    do_load(4'b1111, 1'b1, 3);
    do_load(4'b0110, 1'b0, 1);
    do_load(4'b1001, 1'b1, 6);
    do_load(4'b0011, 1'b0, 7);

    in_valid = 1'b1; abort = 1'b1; in_data = 4'b1100; in_msb_first = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_abort_ready", 32'(in_ready), 1);
      chk("idle_abort_clear", 32'(sr_clear), 0);
      chk("idle_abort_shift", 32'(sr_shift_en), 0);
    end
    in_valid = 1'b0; abort = 1'b0;
    @(negedge clk);

    stuck = 1'b1;
    do_load(4'b0110, 1'b1, 0);
    for (int i = 0; i < 300; i++) do_load(4'b0110, 1'($urandom), 0);
    chk("errcnt_sat", 32'(err_cnt), 255);
    stuck = 1'b0;

    chk("mid_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = 4'b0011; in_msb_first = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("mid_in_shift", 32'(sr_shift_en), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready",  32'(in_ready), 1);
    chk("mid_rst_clear",  32'(sr_clear), 0);
    chk("mid_rst_shift",  32'(sr_shift_en), 0);
    chk("mid_rst_serial", 32'(sr_serial), 0);
    chk("mid_rst_done",   32'(done), 0);
    chk("mid_rst_out",    32'(out_data), 0);
    chk("mid_rst_err",    32'(err), 0);
    chk("mid_rst_errcnt", 32'(err_cnt), 0);
    prev_out = '0; prev_err = 1'b0; m_errcnt = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done",  32'(done), 0);
      chk("post_rst_ready", 32'(in_ready), 1);
    end
    do_load(4'b0101, 1'b1, 0);

    for (int i = 0; i < 28; i++) begin
      exp_ready = (i % 8 == 0) || (i >= 24);
      exp_done  = (i % 8 == 7) && (i < 24);
      chk("b2b_ready", 32'(in_ready), 32'(exp_ready));
      chk("b2b_done",  32'(done), 32'(exp_done));
      if (exp_done) chk("b2b_out", 32'(out_data), 32'(pres[i-7]));
      if (i < 20) begin
        pres[i] = 4'($urandom);
        in_valid = 1'b1; in_data = pres[i]; in_msb_first = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    prev_out = pres[16];

    for (int i = 0; i < 8; i++) do_load(4'($urandom), 1'($urandom), int'($urandom_range(0, 7)));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
